// File: rtl/jedro_1_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jedro_1_mem_arb_pkg
// Description : Shared jedro_1 definitions used by the memory arbiter:
//               datapath width, boot address and the requester-ID encoding
//               carried in the arbiter's one-deep response tag.
// Revision    : 1.0 - initial release
// ============================================================================
package jedro_1_mem_arb_pkg;

  // Core-wide datapath / address width.
  localparam int unsigned JEDRO_DATA_WIDTH = 32;

  // Reset fetch address of the core.
  localparam logic [31:0] JEDRO_BOOT_ADDR = 32'h0000_0000;

  // Which requester owns the memory access issued in a given cycle.
  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_INSTR = 2'd1,
    REQ_DATA  = 2'd2
  } req_id_e;

endpackage : jedro_1_mem_arb_pkg
`default_nettype wire

// File: rtl/jedro_1_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : jedro_1_mem_arb
// Description : Arbitrates a single-port SRAM (1-cycle read latency) between
//               the instruction-fetch port and the load/store port. Data has
//               priority, but an instruction fetch that has waited through
//               STARVE_LIMIT consecutive data grants wins the next tie.
// Ports       : clk_i / rst_i          - clock, synchronous active-high reset
//               i_req_i, i_addr_i      - fetch read request
//               i_gnt_o, i_rvalid_o,
//               i_rdata_o              - fetch grant and read response
//               d_req_i, d_we_i, d_be_i,
//               d_addr_i, d_wdata_i    - load/store request
//               d_gnt_o, d_rvalid_o,
//               d_rdata_o              - load/store grant and response
//               mem_*                  - SRAM port
// Revision    : 1.0 - initial release
// ============================================================================
module jedro_1_mem_arb
  import jedro_1_mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = JEDRO_DATA_WIDTH,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  i_req_i,
  input  logic [DATA_WIDTH-1:0] i_addr_i,
  output logic                  i_gnt_o,
  output logic                  i_rvalid_o,
  output logic [DATA_WIDTH-1:0] i_rdata_o,

  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [3:0]            d_be_i,
  input  logic [DATA_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,

  output logic                  mem_rst_o,
  output logic                  mem_en_o,
  output logic [3:0]            mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int unsigned      CNT_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [DATA_WIDTH-1:0] WORD_MASK = ~DATA_WIDTH'(3);

  logic [CNT_W-1:0]      starve_cnt_d, starve_cnt_q;
  req_id_e               tag_d, tag_q;
  logic                  we_d, we_q;
  logic                  w_gnt_instr;
  logic                  w_gnt_data;
  logic [DATA_WIDTH-1:0] w_addr;

  // Grant decision: data first unless the waiting fetch has hit the limit.
  always_comb begin
    w_gnt_instr = 1'b0;
    w_gnt_data  = 1'b0;
    if (!rst_i) begin
      if (d_req_i && !(i_req_i && (starve_cnt_q == CNT_MAX))) begin
        w_gnt_data = 1'b1;
      end else if (i_req_i) begin
        w_gnt_instr = 1'b1;
      end
    end
  end

  // Starvation counter and response tag next-state.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    tag_d        = REQ_NONE;
    we_d         = 1'b0;

    // Only counts data grants that actually made a fetch wait.
    if (w_gnt_instr || !i_req_i) begin
      starve_cnt_d = '0;
    end else if (w_gnt_data && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end

    if (w_gnt_instr) begin
      tag_d = REQ_INSTR;
    end else if (w_gnt_data) begin
      tag_d = REQ_DATA;
      we_d  = d_we_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
      tag_q        <= REQ_NONE;
      we_q         <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      tag_q        <= tag_d;
      we_q         <= we_d;
    end
  end

  // Memory request path.
  assign w_addr      = w_gnt_instr ? i_addr_i : d_addr_i;
  assign mem_addr_o  = w_addr & WORD_MASK;
  assign mem_en_o    = w_gnt_instr | w_gnt_data;
  assign mem_we_o    = (w_gnt_data && d_we_i) ? d_be_i : 4'b0000;
  assign mem_wdata_o = d_wdata_i;
  assign mem_rst_o   = rst_i;

  assign i_gnt_o = w_gnt_instr;
  assign d_gnt_o = w_gnt_data;

  // Response path. The tag flop clears one edge after rst_i rises, so the
  // rvalids are additionally gated to kill a response already in flight.
  assign i_rvalid_o = !rst_i && (tag_q == REQ_INSTR);
  assign d_rvalid_o = !rst_i && (tag_q == REQ_DATA);
  assign i_rdata_o  = i_rvalid_o ? mem_rdata_i : '0;
  assign d_rdata_o  = (d_rvalid_o && !we_q) ? mem_rdata_i : '0;

endmodule : jedro_1_mem_arb
`default_nettype wire

// File: tb/tb_jedro_1_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_jedro_1_mem_arb
// Description : Self-checking bench for jedro_1_mem_arb. A small SRAM model
//               answers the memory port; a reference model tracks how long
//               the fetch port has been waiting and what data each grant
//               must return.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jedro_1_mem_arb;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o, i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i, d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        mem_rst_o, mem_en_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jedro_1_mem_arb #(
    .DATA_WIDTH  (32),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .i_req_i    (i_req_i),
    .i_addr_i   (i_addr_i),
    .i_gnt_o    (i_gnt_o),
    .i_rvalid_o (i_rvalid_o),
    .i_rdata_o  (i_rdata_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_be_i     (d_be_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_gnt_o    (d_gnt_o),
    .d_rvalid_o (d_rvalid_o),
    .d_rdata_o  (d_rdata_o),
    .mem_rst_o  (mem_rst_o),
    .mem_en_o   (mem_en_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [31:0] init_word(int k);
    return (k * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // SRAM: 64 words, reloaded with a known pattern whenever reset is high.
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (rst_i) begin
      for (int k = 0; k < 64; k++) ram[k] <= init_word(k);
      mem_rdata_i <= 32'h0;
    end else if (mem_en_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_we_o[b]) ram[mem_addr_o[7:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      mem_rdata_i <= ram[mem_addr_o[7:2]];
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [64];
  int          m_wait;     // data grants in a row while fetch was waiting
  int          m_owner;    // 0 none, 1 instr, 2 data: access issued last cycle
  bit          m_wr;       // last data access was a write
  logic [31:0] m_rd;       // word the last read must return
  int          n_igrant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check mid-cycle, then advance the model.
  task automatic step(input bit rst, input bit ir, input logic [31:0] ia,
                      input bit dr, input bit dw, input logic [3:0] be,
                      input logic [31:0] da, input logic [31:0] dwd);
    int          who;
    logic [31:0] a;
    rst_i = rst; i_req_i = ir; i_addr_i = ia;
    d_req_i = dr; d_we_i = dw; d_be_i = be; d_addr_i = da; d_wdata_i = dwd;
    #4;
    if (rst)              who = 0;
    else if (ir && dr)    who = (m_wait == LIMIT) ? 1 : 2;
    else if (dr)          who = 2;
    else if (ir)          who = 1;
    else                  who = 0;
    a = ((who == 1) ? ia : da) & ~32'h3;

    chk("i_gnt", 32'(i_gnt_o), 32'(who == 1));
    chk("d_gnt", 32'(d_gnt_o), 32'(who == 2));
    chk("mem_en", 32'(mem_en_o), 32'(who != 0));
    chk("mem_we", 32'(mem_we_o), (who == 2 && dw) ? 32'(be) : 32'h0);
    chk("mem_rst", 32'(mem_rst_o), 32'(rst));
    if (who != 0) begin
      chk("mem_addr", mem_addr_o, a);
      if (who == 2) chk("mem_wdata", mem_wdata_o, dwd);
    end
    chk("i_rvalid", 32'(i_rvalid_o), 32'(!rst && m_owner == 1));
    chk("d_rvalid", 32'(d_rvalid_o), 32'(!rst && m_owner == 2));
    chk("i_rdata", i_rdata_o, (!rst && m_owner == 1) ? m_rd : 32'h0);
    if (!(!rst && m_owner == 2 && m_wr))
      chk("d_rdata", d_rdata_o, (!rst && m_owner == 2) ? m_rd : 32'h0);
    n_igrant += int'(i_gnt_o);

    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_owner = 0; m_wr = 0;
      for (int k = 0; k < 64; k++) ref_mem[k] = init_word(k);
    end else begin
      if (who == 1 || !ir)                 m_wait = 0;
      else if (who == 2 && m_wait < LIMIT) m_wait++;
      m_owner = who;
      m_wr    = (who == 2) && dw;
      if (who != 0) begin
        m_rd = ref_mem[a[7:2]];
        if (m_wr)
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a[7:2]][8*b +: 8] = dwd[8*b +: 8];
      end
    end
    #1;
  endtask

  initial begin
    m_wait = 0; m_owner = 0; m_wr = 0; m_rd = 32'h0; n_igrant = 0;
    for (int k = 0; k < 64; k++) ref_mem[k] = init_word(k);
    rst_i = 1'b1; i_req_i = 0; i_addr_i = 0; d_req_i = 0; d_we_i = 0;
    d_be_i = 0; d_addr_i = 0; d_wdata_i = 0;
    @(posedge clk); #1;

    // Reset with requests present: everything held low.
    step(1, 1, 32'h40, 1, 1, 4'hF, 32'h44, 32'hDEAD_BEEF);
    step(1, 1, 32'h48, 1, 0, 4'h0, 32'h4C, 32'h0);

    // Idle.
    for (int k = 0; k < 5; k++) step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Fetch only, unaligned address.
    for (int k = 0; k < 3; k++) step(0, 1, 32'h0000_0102, 0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Both reading continuously: D,D,D,D,I twice.
    n_igrant = 0;
    for (int k = 0; k < 10; k++) step(0, 1, 32'(k * 4), 1, 0, 4'h0, 32'h80 + 32'(k * 4), 32'h0);
    chk("starve_pattern_igrants", 32'(n_igrant), 32'd2);

    // Partial write concurrent with a fetch, then fetch alone.
    step(0, 1, 32'h10, 1, 1, 4'b0011, 32'h20, 32'h1234_5678);
    step(0, 1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 1, 0, 4'h0, 32'h20, 32'h0);   // read back merged word

    // Read granted, reset the next cycle: the response is discarded.
    step(0, 1, 32'h30, 0, 0, 4'h0, 32'h0, 32'h0);
    step(1, 1, 32'h34, 1, 0, 4'h0, 32'h38, 32'h0);
    step(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Fetch drops after 3 data grants: wait count clears.
    for (int k = 0; k < 3; k++) step(0, 1, 32'h4, 1, 0, 4'h0, 32'h8, 32'h0);
    step(0, 0, 32'h0, 1, 0, 4'h0, 32'hC, 32'h0);
    n_igrant = 0;
    for (int k = 0; k < 4; k++) step(0, 1, 32'h4, 1, 1, 4'hF, 32'h8, 32'(k));
    chk("no_fetch_after_clear", 32'(n_igrant), 32'd0);
    step(0, 1, 32'h4, 1, 0, 4'h0, 32'h8, 32'h0);

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0), $urandom(),
           ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)), $urandom(), $urandom());
    end
    step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_jedro_1_mem_arb
`default_nettype wire

// File: doc/jedro_1_mem_arb.md
JEDRO_1_MEM_ARB -- requirements
Module: jedro_1_mem_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH (32), instruction/data/address width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, max consecutive data grants while an instruction request waits.
REQ-003 SHALL have port clk_i  in  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_i  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports i_req_i in 1 / i_addr_i in DATA_WIDTH, the instruction-fetch read request and address.
REQ-006 SHALL have ports i_gnt_o out 1 / i_rvalid_o out 1 / i_rdata_o out DATA_WIDTH, the fetch grant and read response.
REQ-007 SHALL have ports d_req_i in 1 / d_we_i in 1 / d_be_i in 4 / d_addr_i in DATA_WIDTH / d_wdata_i in DATA_WIDTH, the load/store request.
REQ-008 SHALL have ports d_gnt_o out 1 / d_rvalid_o out 1 / d_rdata_o out DATA_WIDTH, the load/store grant and response.
REQ-009 SHALL have memory ports mem_rst_o out 1, mem_en_o out 1, mem_we_o out 4, mem_addr_o out DATA_WIDTH, mem_wdata_o out DATA_WIDTH, mem_rdata_i in DATA_WIDTH (single-port SRAM, 1-cycle read latency).

Function
REQ-010 SHALL grant at most one requester per cycle; grants are combinational from the current requests and registered arbitration state.
REQ-011 SHALL assert x_gnt_o only in a cycle where x_req_i is high; the request counts as accepted in that cycle.
REQ-012 SHALL drive mem_en_o=1 in exactly the cycles with a grant and mem_en_o=0 otherwise.
REQ-013 SHALL drive the memory from the granted requester: mem_addr_o = address with bits [1:0] forced to 0; mem_we_o = d_be_i if d_we_i else 0 (instruction grants: 0); mem_wdata_o = d_wdata_i.
REQ-014 SHALL grant data when only data requests, instruction when only instruction requests, none when neither.
REQ-015 SHALL, on simultaneous requests, grant data unless the starvation counter equals STARVE_LIMIT, in which case grant instruction.
REQ-016 SHALL keep a starvation counter (width clog2(STARVE_LIMIT+1)): increment, saturating at STARVE_LIMIT, on a data grant while i_req_i is high; clear on an instruction grant or when i_req_i is low.
REQ-017 SHALL register the granted requester and the write flag (one-deep response tag) every cycle.
REQ-018 SHALL assert x_rvalid_o for exactly one cycle, the cycle after a read grant to x, with x_rdata_o = mem_rdata_i.
REQ-019 SHALL also assert d_rvalid_o one cycle after a data write grant (write acknowledge); d_rdata_o is don't-care then.
REQ-020 SHALL hold x_rdata_o at 0 whenever x_rvalid_o is low.
REQ-021 SHALL sustain back-to-back grants every cycle with no bubble; responses stay in grant order.
REQ-022 SHALL drive mem_rst_o = rst_i combinationally.

Reset
REQ-023 SHALL, while rst_i is high, force all grants, rvalids, mem_en_o and mem_we_o to 0 regardless of requests.
REQ-024 SHALL reset the starvation counter to 0 and the response tag to "none".
REQ-025 SHALL discard a response in flight when rst_i is asserted; no rvalid in the cycle after reset deasserts.

Structure
REQ-026 SHALL take DATA_WIDTH and BOOT_ADDR from the shared jedro_1_defines file; a requester-ID encoding (NONE/INSTR/DATA) SHALL be added there.
REQ-027 SHALL be a single flat module; no sub-module is needed.

Verification
REQ-028 Only i_req_i=1, i_addr_i=0x0000_0102 for 3 cycles -> i_gnt_o=1 each cycle, mem_addr_o=0x100, i_rvalid_o on cycles 2-4 with memory words.
REQ-029 Both requesting continuously, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I repeating; i_rvalid_o once per 5 cycles.
REQ-030 Data write d_be_i=4'b0011 to 0x20 concurrent with instr request -> d_gnt_o=1, mem_we_o=4'b0011, i_gnt_o=0; next cycle d_rvalid_o=1, i_gnt_o=1.
REQ-031 Read grant issued, rst_i asserted next cycle -> no rvalid at all; all outputs 0 during reset.
REQ-032 i_req_i drops after 3 data grants, rises again -> counter clears; next 4 simultaneous cycles grant data.
REQ-033 No requests for 5 cycles -> mem_en_o=0, all rvalids 0, rdata outputs 0.
